// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC fetch sequencer.
//   state_t        - sequencer FSM states (FETCH, WAIT, EXEC, HALT)
//   CAUSE_*        - trap cause codes raised by the sequencer itself
//   PC_STEP        - sequential PC increment
//   PC_RST_DEFAULT - default architectural reset PC
package npc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0]  CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0]  CAUSE_IFAULT   = 4'd1;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_RST_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory request/response bus.
//   imem_req    - fetch request, held until granted (sequencer -> memory)
//   imem_addr   - fetch address (sequencer -> memory)
//   imem_gnt    - request accepted this cycle (memory -> sequencer)
//   imem_rvalid - response valid (memory -> sequencer)
//   imem_rdata  - fetched instruction word (memory -> sequencer)
//   imem_err    - access fault, qualified by imem_rvalid (memory -> sequencer)
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC selection at instruction completion.
// Priority: halt > trap > mret > redirect > sequential.
//   inputs : pc, mtvec, mepc, exu_target, exu_redirect, exu_trap,
//            exu_mret, exu_halt, exu_cause
//   outputs: next_pc   - PC to load when exu_done is sampled
//            take_trap - outcome is a trap (explicit or misaligned target)
//            cause     - trap cause, meaningful with take_trap
//            retire    - instruction counts toward instret
//            go_halt   - enter HALT
module pc_next_mux
  import npc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] exu_target,
  input  logic        exu_redirect,
  input  logic        exu_trap,
  input  logic        exu_mret,
  input  logic        exu_halt,
  input  logic [3:0]  exu_cause,
  output logic [31:0] next_pc,
  output logic        take_trap,
  output logic [3:0]  cause,
  output logic        retire,
  output logic        go_halt
);

  always_comb begin
    next_pc   = pc + PC_STEP;
    take_trap = 1'b0;
    cause     = CAUSE_MISALIGN;
    retire    = 1'b1;
    go_halt   = 1'b0;
    if (exu_halt) begin
      next_pc = pc;
      go_halt = 1'b1;
    end else if (exu_trap) begin
      next_pc   = mtvec;
      take_trap = 1'b1;
      cause     = exu_cause;
      retire    = 1'b0;
    end else if (exu_mret) begin
      next_pc = mepc;
    end else if (exu_redirect) begin
      // A target that is not word aligned faults instead of redirecting.
      if (exu_target[1:0] != 2'b00) begin
        next_pc   = mtvec;
        take_trap = 1'b1;
        cause     = CAUSE_MISALIGN;
        retire    = 1'b0;
      end else begin
        next_pc = exu_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/wait/execute sequencer owning the PC.
//   clk, rst     - clock, synchronous active-high reset
//   imem         - instruction memory bus (master side)
//   inst         - registered instruction for the execute unit
//   inst_valid   - one-cycle pulse on EXEC entry
//   exu_*        - completion status from the execute unit (qualified by exu_done)
//   mtvec, mepc  - trap vector and trap return address
//   pc           - architectural PC
//   trap_taken   - one-cycle pulse after a trapping edge
//   trap_cause   - cause of the latest trap
//   trap_epc     - PC of the latest faulting instruction
//   halted       - high in HALT
//   instret      - 64-bit retired instruction count (wraps)
module pc_sequencer
  import npc_pkg::*;
#(
  parameter logic [31:0] PC_RST = PC_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_sequencer_if.master        imem,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  input  logic                  exu_done,
  input  logic                  exu_redirect,
  input  logic [31:0]           exu_target,
  input  logic                  exu_trap,
  input  logic [3:0]            exu_cause,
  input  logic                  exu_mret,
  input  logic                  exu_halt,
  input  logic [31:0]           mtvec,
  input  logic [31:0]           mepc,
  output logic [31:0]           pc,
  output logic                  trap_taken,
  output logic [3:0]            trap_cause,
  output logic [31:0]           trap_epc,
  output logic                  halted,
  output logic [63:0]           instret
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] next_pc;
  logic        take_trap;
  logic [3:0]  mux_cause;
  logic        retire;
  logic        go_halt;

  pc_next_mux u_pc_next_mux (
    .pc           (pc),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .exu_target   (exu_target),
    .exu_redirect (exu_redirect),
    .exu_trap     (exu_trap),
    .exu_mret     (exu_mret),
    .exu_halt     (exu_halt),
    .exu_cause    (exu_cause),
    .next_pc      (next_pc),
    .take_trap    (take_trap),
    .cause        (mux_cause),
    .retire       (retire),
    .go_halt      (go_halt)
  );

  // Request is gated by rst so memory never sees a fetch during reset.
  assign imem.imem_req  = !rst && (state_q == ST_FETCH);
  assign imem.imem_addr = pc;
  assign halted         = (state_q == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (imem.imem_gnt) state_d = ST_WAIT;
      ST_WAIT:  if (imem.imem_rvalid) state_d = imem.imem_err ? ST_FETCH : ST_EXEC;
      ST_EXEC:  if (exu_done) state_d = go_halt ? ST_HALT : ST_FETCH;
      default:  state_d = ST_HALT;
    endcase
  end

  // Stale rvalid/exu_done outside their own state are ignored by the case.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= PC_RST;
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      trap_taken <= 1'b0;
      trap_cause <= 4'd0;
      trap_epc   <= 32'd0;
      instret    <= 64'd0;
    end else begin
      inst_valid <= 1'b0;
      trap_taken <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            if (imem.imem_err) begin
              pc         <= mtvec;
              trap_taken <= 1'b1;
              trap_cause <= CAUSE_IFAULT;
              trap_epc   <= pc;
            end else begin
              inst       <= imem.imem_rdata;
              inst_valid <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (exu_done) begin
            pc <= next_pc;
            if (retire) instret <= instret + 64'd1;
            if (take_trap) begin
              trap_taken <= 1'b1;
              trap_cause <= mux_cause;
              trap_epc   <= pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction-fetch sequencer for the NPC core. It owns the architectural PC and runs a fetch / wait / execute loop against the instruction bus. It selects the next PC from sequential, branch/jump redirect, trap vector or mret return. It sits between the instruction memory port and the execute unit and replaces free-running per-cycle PC update.

## Interface
- PC_RST, 32'h8000_0000, PC value loaded on reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request; held until granted
- imem_addr  out  32  fetch address; equals pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- imem_err  in  1  access fault; qualified by imem_rvalid
- inst  out  32  registered instruction for the execute unit
- inst_valid  out  1  one-cycle pulse: inst is new
- exu_done  in  1  execute unit finished current inst
- exu_redirect  in  1  taken branch/jump; qualified by exu_done
- exu_target  in  32  redirect target
- exu_trap  in  1  exception; qualified by exu_done
- exu_cause  in  4  exception cause
- exu_mret  in  1  mret; qualified by exu_done
- exu_halt  in  1  ebreak/halt; qualified by exu_done
- mtvec, mepc  in  32 each  trap vector / return address
- pc  out  32  current PC
- trap_taken  out  1  one-cycle pulse on trap entry
- trap_cause  out  4  cause, valid with trap_taken
- trap_epc  out  32  PC of faulting inst, valid with trap_taken
- halted  out  1  high in HALT
- instret  out  64  retired instruction count

## Operation
- States: FETCH, WAIT, EXEC, HALT. Encoding is in the package.
- FETCH: imem_req=1. On imem_gnt, go to WAIT.
- WAIT: on imem_rvalid with no error, latch imem_rdata into inst, go to EXEC, pulse inst_valid on EXEC entry. On imem_rvalid with imem_err, take trap (cause 1, epc=pc), go to FETCH.
- EXEC: wait for exu_done. Priority at exu_done is halt > trap > mret > redirect > sequential:
  - halt: go to HALT; pc unchanged; instret+1.
  - trap: pc<=mtvec; trap_epc<=pc; trap_cause<=exu_cause; instret unchanged.
  - mret: pc<=mepc; instret+1.
  - redirect: if exu_target[1:0]!=0, trap with cause 0 and epc=pc. Otherwise pc<=exu_target and instret+1.
  - sequential: pc<=pc+4 (mod 2^32, wraps silently); instret+1.
  - All non-halt outcomes go to FETCH.
- HALT: terminal. All inputs ignored; only rst exits.
- instret is 64-bit and wraps to 0.

## Timing
- Reset values: pc=PC_RST, state FETCH, inst=0, inst_valid=0, trap_taken=0, trap_cause=0, trap_epc=0, halted=0, instret=0. imem_req is forced 0 while rst=1.
- rst overrides everything at any state, mid-fetch included. A stale imem_rvalid arriving in FETCH or EXEC is ignored.
- imem_gnt in the same cycle as imem_req is accepted. imem_rvalid is sampled only in WAIT; the earliest is one cycle after gnt.
- exu_done may be high in the same cycle as inst_valid (single-cycle execute).
- pc, instret and the trap outputs update on the clock edge that samples exu_done (or the faulting rvalid).
- Minimum loop is 3 cycles per instruction with zero-wait memory: FETCH, WAIT, EXEC.
- trap_taken is high for exactly the one cycle after the trapping edge.

## Structure
- npc_pkg holds the state enum, cause constants (CAUSE_MISALIGN=0, CAUSE_IFAULT=1) and PC_STEP=4.
- One sub-module, pc_next_mux: purely combinational next-PC selection implementing the priority list.
- The state register, pc, inst, counters and trap outputs stay in pc_sequencer.

## Test plan
- Reset: after rst, pc=0x8000_0000, imem_req=1, instret=0. Zero-wait memory with exu_done on inst_valid gives pc=0x8000_0004 after 3 cycles.
- Wait states: gnt delayed 2 cycles and rvalid delayed 3 cycles; imem_req stays held, inst_valid pulses exactly once, pc advances by 4.
- Redirect at pc=0x8000_0010 to 0x8000_0100 gives pc=0x8000_0100. Target 0x8000_0102 gives trap_taken, cause 0, epc=0x8000_0010, pc=mtvec.
- Simultaneous exu_trap+exu_redirect+exu_mret, exu_cause=2: trap wins, pc=mtvec, instret unchanged. Then exu_mret with mepc=0x8000_0040 gives pc=0x8000_0040.
- imem_err with rvalid: trap cause 1, no inst_valid. Later exu_halt: halted=1 and imem_req=0 forever until rst.
- rst asserted in WAIT, then a late rvalid arrives in FETCH: it is ignored. pc=PC_RST, instret=0, and normal fetch resumes.
